// File: rtl/spi_slave.sv
// spi_slave: SPI mode-0 (CPOL=0, CPHA=0) slave, MSB first, with sclk/cs/mosi oversampled in clk_i.
// Latency: SYNC_STAGES+2 clk_i cycles from pin sclk rise to valid_o, and from pin sclk fall to miso_o update.
// Backpressure: none; valid_o is a 1-cycle pulse and tx_buf is resent unchanged if not reloaded.
// Option: define SPI_SLAVE_UNDERRUN_EN to add the sticky tx_underrun_o flag.
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk_i,
    input  logic              aresetn_i,
    input  logic              sclk_i,
    input  logic              cs_i,
    input  logic              mosi_i,
    output logic              miso_o,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o,
    output logic              busy_o
`ifdef SPI_SLAVE_UNDERRUN_EN
    ,
    output logic              tx_underrun_o
`endif
);
    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] cs_sync;
    logic [SYNC_STAGES-1:0] mosi_sync;
    logic                   sclk_s;
    logic                   cs_s;
    logic                   sclk_d;
    logic                   cs_d;
    logic                   mosi_d;
    logic                   sclk_rise;
    logic                   sclk_fall;
    logic                   cs_fall;
    logic                   cs_rise;
    logic [DATA_W-1:0]      tx_buf;
    logic [DATA_W-1:0]      tx_sh;
    logic [DATA_W-1:0]      rx_sh;
    logic [CNT_W-1:0]       bit_cnt;

    assign sclk_s = sclk_sync[SYNC_STAGES-1];
    assign cs_s   = cs_sync[SYNC_STAGES-1];

    // Synchronise the asynchronous SPI pins; cs idles high so a reset never looks like a frame start.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            sclk_sync <= '0;
            cs_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_i};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi_i};
        end
    end

    // Registered edge strobes; mosi is delayed alongside so it lines up with sclk_rise.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            sclk_d    <= 1'b0;
            cs_d      <= 1'b1;
            mosi_d    <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            cs_fall   <= 1'b0;
            cs_rise   <= 1'b0;
        end else begin
            sclk_d    <= sclk_s;
            cs_d      <= cs_s;
            mosi_d    <= mosi_sync[SYNC_STAGES-1];
            sclk_rise <= sclk_s & ~sclk_d;
            sclk_fall <= ~sclk_s & sclk_d;
            cs_fall   <= ~cs_s & cs_d;
            cs_rise   <= cs_s & ~cs_d;
        end
    end

    // Transmit buffer: a load coinciding with a reload lands here after tx_sh has taken the old value.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            tx_buf <= '0;
        end else if (load_i) begin
            tx_buf <= data_i;
        end
    end

    // Frame FSM: shifts rx on sclk rise, tx on sclk fall, reloads tx at every word boundary.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state   <= IDLE;
            tx_sh   <= '0;
            rx_sh   <= '0;
            bit_cnt <= '0;
            miso_o  <= 1'b0;
            data_o  <= '0;
            valid_o <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                IDLE: begin
                    miso_o <= 1'b0;
                    busy_o <= 1'b0;
                    if (cs_fall) begin
                        state   <= SHIFT;
                        busy_o  <= 1'b1;
                        tx_sh   <= tx_buf;
                        miso_o  <= tx_buf[DATA_W-1];
                        bit_cnt <= '0;
                        // An sclk rise seen together with cs_fall is the first bit of the word.
                        if (sclk_rise) begin
                            rx_sh   <= {rx_sh[DATA_W-2:0], mosi_d};
                            bit_cnt <= CNT_W'(1);
                        end
                    end
                end
                SHIFT: begin
                    busy_o <= 1'b1;
                    if (cs_rise) begin
                        // Partial word is dropped; data_o keeps the last complete word.
                        state   <= IDLE;
                        busy_o  <= 1'b0;
                        miso_o  <= 1'b0;
                        bit_cnt <= '0;
                    end else if (sclk_rise) begin
                        rx_sh <= {rx_sh[DATA_W-2:0], mosi_d};
                        if (bit_cnt == LAST_BIT) begin
                            data_o  <= {rx_sh[DATA_W-2:0], mosi_d};
                            valid_o <= 1'b1;
                            bit_cnt <= '0;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else if (sclk_fall) begin
                        if (bit_cnt != '0) begin
                            tx_sh  <= tx_sh << 1;
                            miso_o <= tx_sh[DATA_W-2];
                        end else begin
                            tx_sh  <= tx_buf;
                            miso_o <= tx_buf[DATA_W-1];
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SPI_SLAVE_UNDERRUN_EN
    logic any_reload;
    logic bnd_reload;
    logic loaded_q;

    assign bnd_reload = (state == SHIFT) && !cs_rise && !sclk_rise && sclk_fall && (bit_cnt == '0);
    assign any_reload = bnd_reload || ((state == IDLE) && cs_fall);

    // Underrun: a word-boundary reload with no load since the previous reload; sticky until cs_rise.
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            loaded_q      <= 1'b0;
            tx_underrun_o <= 1'b0;
        end else begin
            if (any_reload) begin
                loaded_q <= load_i;
            end else if (load_i) begin
                loaded_q <= 1'b1;
            end
            if ((state == SHIFT) && cs_rise) begin
                tx_underrun_o <= 1'b0;
            end else if (bnd_reload && !loaded_q) begin
                tx_underrun_o <= 1'b1;
            end
        end
    end
`endif

endmodule
